// File: rtl/frame_sync_descrambler_14.sv
// Receive-side frame synchroniser and descrambler: hunts for the sync word,
// confirms alignment, then strips the 147-bit Galois LFSR keystream from the payload.
module frame_sync_descrambler_14 #(
  parameter int          POLY_WIDTH   = 147,
  parameter int          NUM_OF_STEPS = 12,
  parameter int          FRAME_LEN    = 64,
  parameter logic [11:0] SYNC_WORD    = 12'hB4F,
  parameter int          LOCK_CNT     = 2,
  parameter int          LOSS_CNT     = 3,
  parameter logic [11:0] BASE_ADDR    = 12'h0f8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write,
  input  logic [11:0]             addr,
  input  logic [31:0]             lfsrdin,
  input  logic                    din_valid,
  input  logic [NUM_OF_STEPS-1:0] din,
  output logic                    dout_valid,
  output logic [NUM_OF_STEPS-1:0] dout,
  output logic                    locked,
  output logic [7:0]              sync_err_cnt
);

  localparam int FPOS_W = $clog2(FRAME_LEN);
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [POLY_WIDTH-1:0]   lfsr_r, seed_r;
  logic [FPOS_W-1:0]       fpos_r, fpos_nxt_s, fpos_inc_s;
  logic [CNT_W-1:0]        good_r, good_nxt_s, miss_r, miss_nxt_s;
  logic [NUM_OF_STEPS-1:0] dout_r;
  logic                    dout_valid_r, locked_r;
  logic [7:0]              sync_err_cnt_r;
  logic [11:0]             seed_off_s;
  logic                    seed_wr_s, is_sync_s, reload_s, advance_s, emit_s, err_inc_s;

  function automatic logic [POLY_WIDTH-1:0] galois_step(input logic [POLY_WIDTH-1:0] s);
    logic [POLY_WIDTH-1:0] n;
    n     = {s[POLY_WIDTH-2:0], s[POLY_WIDTH-1]};
    n[43] = s[42]  ^ s[POLY_WIDTH-1];
    n[89] = s[88]  ^ s[POLY_WIDTH-1];
    n[110] = s[109] ^ s[POLY_WIDTH-1];
    return n;
  endfunction

  function automatic logic [POLY_WIDTH-1:0] galois_advance(input logic [POLY_WIDTH-1:0] s);
    logic [POLY_WIDTH-1:0] n;
    n = s;
    for (int i = 0; i < NUM_OF_STEPS; i++) begin
      n = galois_step(n);
    end
    return n;
  endfunction

  // Offset wraps for addresses below the base, so one compare covers the whole window
  assign seed_off_s = addr - BASE_ADDR;
  assign seed_wr_s  = write && (seed_off_s < 12'd5);
  assign is_sync_s  = (din == SYNC_WORD);
  assign fpos_inc_s = (fpos_r == FPOS_W'(FRAME_LEN - 1)) ? {FPOS_W{1'b0}} : fpos_r + {{(FPOS_W-1){1'b0}}, 1'b1};

  // Next-state and per-word control decode
  always_comb begin
    state_nxt_s = state_r;
    fpos_nxt_s  = fpos_r;
    good_nxt_s  = good_r;
    miss_nxt_s  = miss_r;
    reload_s    = 1'b0;
    advance_s   = 1'b0;
    emit_s      = 1'b0;
    err_inc_s   = 1'b0;
    if (seed_wr_s) begin
      state_nxt_s = HUNT;
      fpos_nxt_s  = {FPOS_W{1'b0}};
      good_nxt_s  = {CNT_W{1'b0}};
      miss_nxt_s  = {CNT_W{1'b0}};
    end else if (din_valid) begin
      case (state_r)
        HUNT: begin
          if (is_sync_s) begin
            reload_s    = 1'b1;
            fpos_nxt_s  = {{(FPOS_W-1){1'b0}}, 1'b1};
            good_nxt_s  = {{(CNT_W-1){1'b0}}, 1'b1};
            miss_nxt_s  = {CNT_W{1'b0}};
            state_nxt_s = CONFIRM;
          end else begin
            state_nxt_s = HUNT;
          end
        end
        CONFIRM: begin
          fpos_nxt_s = fpos_inc_s;
          if (fpos_r != {FPOS_W{1'b0}}) begin
            advance_s = 1'b1;
          end else if (is_sync_s) begin
            reload_s   = 1'b1;
            good_nxt_s = good_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (good_nxt_s == CNT_W'(LOCK_CNT)) begin
              state_nxt_s = LOCKED;
              miss_nxt_s  = {CNT_W{1'b0}};
            end else begin
              state_nxt_s = CONFIRM;
            end
          end else begin
            state_nxt_s = HUNT;
            good_nxt_s  = {CNT_W{1'b0}};
          end
        end
        LOCKED: begin
          fpos_nxt_s = fpos_inc_s;
          if (fpos_r != {FPOS_W{1'b0}}) begin
            advance_s = 1'b1;
            emit_s    = 1'b1;
          end else if (is_sync_s) begin
            reload_s   = 1'b1;
            miss_nxt_s = {CNT_W{1'b0}};
          end else begin
            // Flywheel: keep the keystream aligned across a corrupted sync
            reload_s   = 1'b1;
            err_inc_s  = 1'b1;
            miss_nxt_s = miss_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (miss_nxt_s == CNT_W'(LOSS_CNT)) begin
              state_nxt_s = HUNT;
            end else begin
              state_nxt_s = LOCKED;
            end
          end
        end
        default: begin
          state_nxt_s = HUNT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, counters, seed, keystream and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= HUNT;
      lfsr_r         <= {POLY_WIDTH{1'b0}};
      seed_r         <= {POLY_WIDTH{1'b0}};
      fpos_r         <= {FPOS_W{1'b0}};
      good_r         <= {CNT_W{1'b0}};
      miss_r         <= {CNT_W{1'b0}};
      dout_r         <= {NUM_OF_STEPS{1'b0}};
      dout_valid_r   <= 1'b0;
      locked_r       <= 1'b0;
      sync_err_cnt_r <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      locked_r     <= (state_nxt_s == LOCKED);
      fpos_r       <= fpos_nxt_s;
      good_r       <= good_nxt_s;
      miss_r       <= miss_nxt_s;
      dout_valid_r <= emit_s;
      if (seed_wr_s) begin
        case (seed_off_s[2:0])
          3'd0:    seed_r[31:0]    <= lfsrdin;
          3'd1:    seed_r[63:32]   <= lfsrdin;
          3'd2:    seed_r[95:64]   <= lfsrdin;
          3'd3:    seed_r[127:96]  <= lfsrdin;
          3'd4:    seed_r[146:128] <= lfsrdin[18:0];
          default: seed_r          <= seed_r;
        endcase
      end
      if (reload_s) begin
        lfsr_r <= seed_r;
      end else if (advance_s) begin
        lfsr_r <= galois_advance(lfsr_r);
      end
      if (emit_s) begin
        dout_r <= din ^ lfsr_r[POLY_WIDTH-1 -: NUM_OF_STEPS];
      end
      if (err_inc_s && (sync_err_cnt_r != 8'hFF)) begin
        sync_err_cnt_r <= sync_err_cnt_r + 8'd1;
      end
    end
  end

  assign dout_valid   = dout_valid_r;
  assign dout         = dout_r;
  assign locked       = locked_r;
  assign sync_err_cnt = sync_err_cnt_r;

endmodule

// File: tb/tb_frame_sync_descrambler_14.sv
// Scenario bench for frame_sync_descrambler_14: a transmit-scrambler model builds
// line frames from random payload and each task checks the recovered stream.
module tb_frame_sync_descrambler_14;

  localparam logic [11:0] SYNC = 12'hB4F;
  localparam logic [11:0] BASE = 12'h0f8;

  logic        clk = 1'b0;
  logic        rst, write, din_valid;
  logic [11:0] addr, din;
  logic [31:0] lfsrdin;
  logic        dout_valid, locked;
  logic [11:0] dout;
  logic [7:0]  sync_err_cnt;

  int checks = 0;
  int errors = 0;
  int idle_bad = 0;

  logic [146:0] tx_seed;
  logic [11:0]  fr_exp  [64];
  logic [11:0]  fr_dout [64];
  logic         fr_dv   [64];
  logic         fr_lk   [64];

  frame_sync_descrambler_14 dut (
    .clk(clk), .rst(rst), .write(write), .addr(addr), .lfsrdin(lfsrdin),
    .din_valid(din_valid), .din(din), .dout_valid(dout_valid), .dout(dout),
    .locked(locked), .sync_err_cnt(sync_err_cnt)
  );

  always #5 clk = ~clk;

  // One Galois step written bit by bit from the shift/tap rule
  function automatic logic [146:0] tx_step(input logic [146:0] s);
    logic [146:0] n;
    for (int b = 146; b > 0; b--) n[b] = s[b-1];
    n[0]   = s[146];
    n[43]  = n[43]  ^ s[146];
    n[89]  = n[89]  ^ s[146];
    n[110] = n[110] ^ s[146];
    return n;
  endfunction

  task automatic idle_cycle();
    logic [11:0] prev;
    prev = dout;
    din_valid = 1'b0;
    @(posedge clk); #1;
    if (dout_valid !== 1'b0 || dout !== prev) idle_bad++;
  endtask

  // Builds one line frame from the transmit model, drives it and records the outputs per word
  task automatic send_frame(input bit bad_sync, input bit raw, input int gap_pct);
    logic [146:0] st;
    logic [11:0]  ks, pt, line;
    st = tx_seed;
    for (int i = 0; i < 64; i++) begin
      if (i == 0) begin
        line = bad_sync ? (SYNC ^ 12'h801) : SYNC;
        fr_exp[i] = 12'h000;
      end else begin
        ks = st[146:135];
        for (int k = 0; k < 12; k++) st = tx_step(st);
        if (raw) begin
          line = 12'h000;
          fr_exp[i] = ks;
        end else begin
          do begin
            pt = 12'($urandom);
            line = pt ^ ks;
          end while (line == SYNC);
          fr_exp[i] = pt;
        end
      end
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idle_cycle();
      din_valid = 1'b1;
      din = line;
      @(posedge clk); #1;
      din_valid = 1'b0;
      fr_dv[i] = dout_valid;
      fr_dout[i] = dout;
      fr_lk[i] = locked;
    end
  endtask

  task automatic write_seed_word(input int n, input logic [31:0] d, input logic dv, input logic [11:0] dw);
    write = 1'b1;
    addr = BASE + 12'(n);
    lfsrdin = d;
    din_valid = dv;
    din = dw;
    @(posedge clk); #1;
    write = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic load_seed(input logic [146:0] s, input logic [12:0] junk);
    for (int n = 0; n < 4; n++) write_seed_word(n, s[32*n +: 32], 1'b0, 12'h000);
    write_seed_word(4, {junk, s[146:128]}, 1'b0, 12'h000);
    tx_seed = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 12'h000 || locked !== 1'b0 || sync_err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: dv=%0b dout=%h locked=%0b err=%0d, want 0/000/0/0", dout_valid, dout, locked, sync_err_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_seed1();
    load_seed(147'h1, 13'h1abc);
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b0, 1'b1, 0);
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (fr_dv[i] !== (f >= 1 && i != 0) || (f >= 1 && i != 0 && fr_dout[i] !== fr_exp[i])) begin
          errors++;
          $display("FAIL lock_seed1 f%0d w%0d: dv=%0b dout=%h want dv=%0b dout=%h", f, i, fr_dv[i], fr_dout[i], (f >= 1 && i != 0), fr_exp[i]);
        end
      end
      checks++;
      if (fr_lk[0] !== (f >= 1)) begin
        errors++;
        $display("FAIL lock_seed1_locked f%0d: locked=%0b want %0b", f, fr_lk[0], (f >= 1));
      end
    end
    for (int i = 1; i <= 13; i++) begin
      checks++;
      if (fr_dout[i] !== ((i == 13) ? 12'h200 : 12'h000)) begin
        errors++;
        $display("FAIL seed1_ks w%0d: dout=%h want %h", i - 1, fr_dout[i], (i == 13) ? 12'h200 : 12'h000);
      end
    end
  endtask

  task automatic test_flywheel();
    bit bad [3] = '{1'b1, 1'b1, 1'b0};
    for (int f = 0; f < 3; f++) begin
      send_frame(bad[f], 1'b0, 0);
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (fr_dv[i] !== (i != 0) || (i != 0 && fr_dout[i] !== fr_exp[i]) || fr_lk[i] !== 1'b1) begin
          errors++;
          $display("FAIL flywheel f%0d w%0d: dv=%0b dout=%h lk=%0b want dv=%0b dout=%h lk=1", f, i, fr_dv[i], fr_dout[i], fr_lk[i], (i != 0), fr_exp[i]);
        end
      end
    end
    checks++;
    if (sync_err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL flywheel_errcnt: got %0d want 2", sync_err_cnt);
    end
  endtask

  task automatic test_loss();
    bit want [3] = '{1'b1, 1'b1, 1'b0};
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b1, 1'b0, 0);
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (fr_dv[i] !== (want[f] && i != 0) || (want[f] && i != 0 && fr_dout[i] !== fr_exp[i])) begin
          errors++;
          $display("FAIL loss f%0d w%0d: dv=%0b dout=%h want dv=%0b dout=%h", f, i, fr_dv[i], fr_dout[i], (want[f] && i != 0), fr_exp[i]);
        end
      end
      checks++;
      if (fr_lk[0] !== want[f]) begin
        errors++;
        $display("FAIL loss_locked f%0d: locked=%0b want %0b", f, fr_lk[0], want[f]);
      end
    end
    checks++;
    if (sync_err_cnt !== 8'd5) begin
      errors++;
      $display("FAIL loss_errcnt: got %0d want 5", sync_err_cnt);
    end
  endtask

  task automatic test_confirm_fail();
    bit bad  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit want [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int f = 0; f < 4; f++) begin
      send_frame(bad[f], 1'b0, 0);
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (fr_dv[i] !== (want[f] && i != 0) || (want[f] && i != 0 && fr_dout[i] !== fr_exp[i])) begin
          errors++;
          $display("FAIL confirm f%0d w%0d: dv=%0b dout=%h want dv=%0b dout=%h", f, i, fr_dv[i], fr_dout[i], (want[f] && i != 0), fr_exp[i]);
        end
      end
      checks++;
      if (fr_lk[0] !== want[f]) begin
        errors++;
        $display("FAIL confirm_locked f%0d: locked=%0b want %0b", f, fr_lk[0], want[f]);
      end
    end
  endtask

  task automatic test_seed_write_locked();
    logic [31:0] d;
    d = $urandom;
    write_seed_word(4, d, 1'b1, SYNC);
    tx_seed[146:128] = d[18:0];
    checks++;
    if (locked !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL seed_write: locked=%0b dv=%0b want 0/0", locked, dout_valid);
    end
    for (int f = 0; f < 2; f++) begin
      send_frame(1'b0, 1'b0, 0);
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (fr_dv[i] !== (f == 1 && i != 0) || (f == 1 && i != 0 && fr_dout[i] !== fr_exp[i])) begin
          errors++;
          $display("FAIL seed_relock f%0d w%0d: dv=%0b dout=%h want dv=%0b dout=%h", f, i, fr_dv[i], fr_dout[i], (f == 1 && i != 0), fr_exp[i]);
        end
      end
    end
  endtask

  task automatic test_random_gapped();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    load_seed(r[146:0], 13'($urandom));
    idle_bad = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b0, 1'b0, 50);
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (fr_dv[i] !== (f >= 1 && i != 0) || (f >= 1 && i != 0 && fr_dout[i] !== fr_exp[i])) begin
          errors++;
          $display("FAIL gapped f%0d w%0d: dv=%0b dout=%h want dv=%0b dout=%h", f, i, fr_dv[i], fr_dout[i], (f >= 1 && i != 0), fr_exp[i]);
        end
      end
    end
    checks++;
    if (idle_bad !== 0) begin
      errors++;
      $display("FAIL gapped_idle: %0d idle cycles changed dout/dout_valid, want 0", idle_bad);
    end
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 3; k++) begin
      din_valid = 1'b1;
      din = 12'h123 + 12'(k);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 12'h000 || locked !== 1'b0 || sync_err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midframe_rst: dv=%0b dout=%h locked=%0b err=%0d, want 0/000/0/0", dout_valid, dout, locked, sync_err_cnt);
    end
    tx_seed = 147'h0;
    for (int f = 0; f < 2; f++) begin
      send_frame(1'b0, 1'b0, 0);
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (fr_dv[i] !== (f == 1 && i != 0) || (f == 1 && i != 0 && fr_dout[i] !== fr_exp[i])) begin
          errors++;
          $display("FAIL midframe_relock f%0d w%0d: dv=%0b dout=%h want dv=%0b dout=%h", f, i, fr_dv[i], fr_dout[i], (f == 1 && i != 0), fr_exp[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    write = 1'b0;
    addr = 12'h000;
    lfsrdin = 32'h0;
    din_valid = 1'b0;
    din = 12'h000;
    tx_seed = 147'h0;
    test_reset();
    test_lock_seed1();
    test_flywheel();
    test_loss();
    test_confirm_fail();
    test_seed_write_locked();
    test_random_gapped();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
